// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory path: responder state encoding and data constants.
package cpu_mem_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W data storage: synchronous write, registered read, contents never reset.
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port and registered read port; one access per cycle.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    if (re) begin
      rd_data <= mem_r[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with WAIT_CYCLES wait states and a pipeline stall.
// Optional address-error reporting is enabled with the DMEM_ERR_EN macro.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
`ifdef DMEM_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_r;
  state_t            state_next_s;
  logic [3:0]        cnt_r;
  logic [AW-1:0]     idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic              write_r;
  logic              bad_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rvalid_r;
  logic              req_any_s;
  logic              access_s;
  logic              bad_in_s;
  logic              arr_we_s;
  logic              arr_re_s;
  logic [AW-1:0]     arr_addr_s;
  logic [DATA_W-1:0] arr_rdata_s;

  assign req_any_s = req_read | req_write;
  assign access_s  = (state_r == BUSY) && (cnt_r == 4'd0);

`ifdef DMEM_ERR_EN
  logic err_r;
  assign bad_in_s = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
  assign err      = err_r;
`else
  logic unused_addr_s;
  assign bad_in_s      = 1'b0;
  assign unused_addr_s = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // The array is read ahead during IDLE/BUSY so its registered output is ready at the access edge.
  assign arr_addr_s = (state_r == IDLE) ? req_addr[2 +: AW] : idx_r;
  assign arr_re_s   = ((state_r == IDLE) && req_read && !req_write) ||
                      ((state_r == BUSY) && !write_r);
  assign arr_we_s   = access_s && write_r && !bad_r;

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clock  (clock),
    .we     (arr_we_s),
    .re     (arr_re_s),
    .addr   (arr_addr_s),
    .wdata  (wdata_r),
    .rd_data(arr_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and stall decode.
  always_comb begin
    state_next_s = state_r;
    stall        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          stall        = 1'b1;
          state_next_s = BUSY;
        end else begin
          stall        = 1'b0;
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
        end else begin
          state_next_s = BUSY;
        end
      end
      RESP: begin
        stall        = 1'b0;
        state_next_s = IDLE;
      end
      default: begin
        stall        = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and load result; a write takes priority over a simultaneous read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r    <= 4'd0;
      idx_r    <= '0;
      wdata_r  <= 32'h0000_0000;
      write_r  <= 1'b0;
      bad_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rvalid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            idx_r   <= req_addr[2 +: AW];
            wdata_r <= req_wdata;
            write_r <= req_write;
            bad_r   <= bad_in_s;
            cnt_r   <= 4'(WAIT_CYCLES);
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (!write_r) begin
            rdata_r <= bad_r ? ERR_PATTERN : arr_rdata_s;
          end
        end
        default: begin
        end
      endcase
      rvalid_r <= access_s && !write_r;
    end
  end

`ifdef DMEM_ERR_EN
  // Error flag is visible only during the RESP cycle of a faulty access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= access_s && bad_r;
    end
  end
`endif

endmodule
